booth_mult_seq: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier. The controller FSM and the A/M/Q datapath are in one block.
- Generalises the fixed 4-bit controller to WIDTH-bit operands.
- Adds a signed/unsigned mode, a start/busy/done handshake and a held product register.
- Sits between the operand-register front end and result consumers; one multiply in flight at a time.

---
 rtl/booth_mult_seq.sv | 80 ++++++++
 tb/tb_booth_mult_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with signed/unsigned mode and start/busy/done handshake
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signedMode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    localparam int E = WIDTH + 1;
    typedef enum logic [1:0] {IDLE, ADDSUB, SHIFT, DONE} stateT;
    stateT            state;
    logic [E-1:0]     a;
    logic [E-1:0]     m;
    logic [E-1:0]     q;
    logic             qm1;
    logic [CNT_W-1:0] count;
    // Controller and A/M/Q datapath; one extra operand bit makes unsigned operands exact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {signedMode & multiplicand[WIDTH-1], multiplicand};
                        q     <= {signedMode & multiplier[WIDTH-1], multiplier};
                        a     <= '0;
                        qm1   <= 1'b0;
                        count <= CNT_W'(E);
                        busy  <= 1'b1;
                        state <= ADDSUB;
                    end
                end
                ADDSUB: begin
                    a     <= (q[0] & ~qm1) ? a - m : (~q[0] & qm1) ? a + m : a;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a     <= {a[E-1], a[E-1:1]};
                    q     <= {a[0], q[E-1:1]};
                    qm1   <= q[0];
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        product <= {a[WIDTH-1:0], q[WIDTH:1]};
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= ADDSUB;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: vector table, corner sequences and randomized checks against an arithmetic reference
module tb_booth_mult_seq;
    localparam int W = 8;
    localparam int E = W + 1;
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           signedMode = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] lastExp = '0;

    typedef struct {
        logic           sm;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vecT;
    vecT vecs[7];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .signedMode(signedMode),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] refProd(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
        longint p;
        p = sm ? longint'($signed(m)) * longint'($signed(q)) : longint'(m) * longint'(q);
        return p[2*W-1:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic runOp(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input int injectAt);
        int cyc = 0;
        int busyCnt = 0;
        int holdBad = 0;
        bit seen = 0;
        start = 1'b1; signedMode = sm; multiplicand = m; multiplier = q;
        @(posedge clk);
        #1 start = 1'b0; signedMode = 1'($urandom); multiplicand = W'($urandom); multiplier = W'($urandom);
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) seen = 1;
            else begin
                if (product !== lastExp) holdBad++;
                cyc++;
            end
            if (cyc == injectAt && !seen) begin
                start = 1'b1; signedMode = 1'b0; multiplicand = 8'h09; multiplier = 8'h09;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        check("doneSeen", 32'(seen), 32'd1);
        check("latency", cyc, 2 * E);
        check("busyCycles", busyCnt, 2 * E + 1);
        check("product", product, exp);
        check("productHold", holdBad, 0);
        @(negedge clk);
        check("donePulse", done, 0);
        check("busyOff", busy, 0);
        lastExp = exp;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[1] = '{1'b0, 8'hC8, 8'h03, 16'h0258};
        vecs[2] = '{1'b1, 8'hC8, 8'h03, 16'hFF58};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[5] = '{1'b1, 8'h00, 8'h7F, 16'h0000};
        vecs[6] = '{1'b0, 8'h7F, 8'h00, 16'h0000};

        repeat (3) @(negedge clk);
        check("rstBusy", busy, 0);
        check("rstDone", done, 0);
        check("rstProduct", product, 0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) runOp(vecs[i].sm, vecs[i].m, vecs[i].q, vecs[i].exp, -1);

        runOp(1'b0, 8'h02, 8'h03, 16'h0006, 5);
        begin
            int extra = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done) extra++;
                if (product !== 16'h0006) extra += 100;
            end
            check("ignoredStart", extra, 0);
        end
        runOp(1'b0, 8'h0B, 8'h0D, 16'h008F, -1);

        start = 1'b1; signedMode = 1'b0; multiplicand = 8'h11; multiplier = 8'h22;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abortBusy", busy, 0);
        check("abortDone", done, 0);
        check("abortProduct", product, 0);
        @(negedge clk);
        reset = 1'b1;
        lastExp = '0;
        @(negedge clk);
        runOp(1'b1, 8'hF0, 8'h07, 16'hFF90, -1);

        for (int i = 0; i < 20; i++) begin
            logic sm;
            logic [W-1:0] m, q;
            sm = 1'($urandom); m = W'($urandom); q = W'($urandom);
            runOp(sm, m, q, refProd(sm, m, q), -1);
        end

        begin
            int ph = 0;
            int dones = 0;
            logic [2*W-1:0] hexp = lastExp;
            start = 1'b1; signedMode = 1'($urandom); multiplicand = W'($urandom); multiplier = W'($urandom);
            for (int i = 0; i < 90; i++) begin
                @(posedge clk);
                if (ph == 0) begin
                    ph = 1;
                    hexp = refProd(signedMode, multiplicand, multiplier);
                end else if (ph == 2 * E + 1) ph = 0;
                else ph++;
                @(negedge clk);
                check("heldBusy", busy, 32'(ph != 0));
                check("heldDone", done, 32'(ph == 2 * E + 1));
                if (ph == 2 * E + 1) begin
                    dones++;
                    check("heldProduct", product, hexp);
                end
                signedMode = 1'($urandom); multiplicand = W'($urandom); multiplier = W'($urandom);
            end
            start = 1'b0;
            check("heldDoneCount", dones, 4);
        end

        repeat (30) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
